// File: rtl/farrow_interpolator.sv
// Piecewise-parabolic (alpha = 0.5) Farrow interpolator: 4-tap delay line,
// fill-gated strobe acceptance and a 3-stage Horner pipeline with output saturation.
module farrow_interpolator #(
  parameter int DATA_WIDTH = 16,
  parameter int MU_WIDTH   = 16,
  parameter int MU_FRAC    = 14
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         din_valid,
  input  logic                         mk,
  input  logic        [MU_WIDTH-1:0]   uk,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid
);
  localparam int DW  = DATA_WIDTH;
  localparam int CW  = DW + 3;
  localparam int TW  = DW + 4;
  localparam int P1W = DW + 2 + MU_FRAC + 1;
  localparam int P2W = TW + MU_FRAC + 1;
  localparam int YW  = DW + 6;
  localparam logic signed [YW-1:0] Y_MAX = {{(YW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [YW-1:0] Y_MIN = {{(YW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0] d0, d1, d2, d3;
  logic [2:0] fill;
  logic accept;

  assign accept = mk && din_valid && (fill == 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      d0   <= '0;
      d1   <= '0;
      d2   <= '0;
      d3   <= '0;
      fill <= '0;
    end else if (din_valid) begin
      d0 <= din;
      d1 <= d0;
      d2 <= d1;
      d3 <= d2;
      if (fill != 3'd4) fill <= fill + 3'd1;
    end
  end

  // Coefficients use the taps as they stood before this cycle's shift
  logic signed [CW-1:0] e0, e1, e2, e3, v1_full, v2_full;
  assign e0 = {{3{d0[DW-1]}}, d0};
  assign e1 = {{3{d1[DW-1]}}, d1};
  assign e2 = {{3{d2[DW-1]}}, d2};
  assign e3 = {{3{d3[DW-1]}}, d3};
  assign v1_full = (e1 <<< 1) + e1 - e0 - e2 - e3;
  assign v2_full = e0 - e1 - e2 + e3;

  logic [MU_FRAC-1:0] mu;
  assign mu = (|uk[MU_WIDTH-1:MU_FRAC]) ? {MU_FRAC{1'b1}} : uk[MU_FRAC-1:0];

  logic                 s1_valid;
  logic signed [DW-1:0] s1_v0;
  logic signed [DW+1:0] s1_v1, s1_v2;
  logic [MU_FRAC-1:0]   s1_mu;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_v0    <= '0;
      s1_v1    <= '0;
      s1_v2    <= '0;
      s1_mu    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_v0 <= d2;
        s1_v1 <= v1_full[CW-1:1];
        s1_v2 <= v2_full[CW-1:1];
        s1_mu <= mu;
      end
    end
  end

  logic signed [P1W-1:0] p1;
  logic signed [DW+2:0]  p1_hi;
  logic signed [TW-1:0]  t_next;
  assign p1     = $signed({{(MU_FRAC+1){s1_v2[DW+1]}}, s1_v2}) * $signed({{(DW+3){1'b0}}, s1_mu});
  assign p1_hi  = p1[P1W-1:MU_FRAC];
  assign t_next = $signed({p1_hi[DW+2], p1_hi}) + $signed({{2{s1_v1[DW+1]}}, s1_v1});

  logic                 s2_valid;
  logic signed [TW-1:0] s2_t;
  logic signed [DW-1:0] s2_v0;
  logic [MU_FRAC-1:0]   s2_mu;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_t     <= '0;
      s2_v0    <= '0;
      s2_mu    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_t  <= t_next;
        s2_v0 <= s1_v0;
        s2_mu <= s1_mu;
      end
    end
  end

  logic signed [P2W-1:0] p2;
  logic signed [TW:0]    p2_hi;
  logic signed [YW-1:0]  y;
  logic signed [DW-1:0]  y_sat;
  assign p2    = $signed({{(MU_FRAC+1){s2_t[TW-1]}}, s2_t}) * $signed({{(TW+1){1'b0}}, s2_mu});
  assign p2_hi = p2[P2W-1:MU_FRAC];
  assign y     = $signed({p2_hi[TW], p2_hi}) + $signed({{6{s2_v0[DW-1]}}, s2_v0});

  always_comb begin
    y_sat = y[DW-1:0];
    if (y > Y_MAX)      y_sat = Y_MAX[DW-1:0];
    else if (y < Y_MIN) y_sat = Y_MIN[DW-1:0];
  end

  // Floor shifts simply drop these low bits
  logic unused_bits;
  assign unused_bits = ^{v1_full[0], v2_full[0], p1[MU_FRAC-1:0], p2[MU_FRAC-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= s2_valid;
      if (s2_valid) dout <= y_sat;
    end
  end
endmodule

// File: tb/tb_farrow_interpolator.sv
// Directed testbench for farrow_interpolator: table of tap/mu vectors with
// hand-computed results plus sequences for fill gating, gaps and reset.
module tb_farrow_interpolator;
  localparam int DW = 16;
  localparam int MW = 16;
  localparam int MF = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic                 mk;
  logic [MW-1:0]        uk;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;

  always #5 clk = ~clk;

  farrow_interpolator #(.DATA_WIDTH(DW), .MU_WIDTH(MW), .MU_FRAC(MF)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .mk(mk), .uk(uk), .dout(dout), .dout_valid(dout_valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int obs_val[$];
  int obs_cyc[$];
  always @(negedge clk) begin
    if (dout_valid) begin
      obs_val.push_back(int'(dout));
      obs_cyc.push_back(cyc);
    end
  end

  int total = 0;
  int bad = 0;
  int strobe_cyc = 0;

  typedef struct {
    int    d3, d2, d1, d0;
    int    u;
    int    exp;
    string name;
  } vec_t;
  vec_t vecs[13];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic dv, input int d, input logic m, input int u);
    rst       = r;
    din_valid = dv;
    din       = DW'(d);
    mk        = m;
    uk        = MW'(u);
    if (m) strobe_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    rst = 1'b0;
  endtask

  task automatic clearObs();
    obs_val.delete();
    obs_cyc.delete();
  endtask

  task automatic loadTaps(input int a3, input int a2, input int a1, input int a0);
    applyStimulus(1'b0, 1'b1, a3, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, a2, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, a1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, a0, 1'b0, 0);
  endtask

  task automatic expectOne(input string name, input int expected);
    idle(5);
    checkOutput({name, "_count"}, obs_val.size(), 1);
    if (obs_val.size() >= 1) begin
      checkOutput({name, "_value"}, obs_val[0], expected);
      checkOutput({name, "_latency"}, obs_cyc[0] - strobe_cyc, 3);
    end
    checkOutput({name, "_hold"}, int'(dout), expected);
  endtask

  initial begin
    vecs[0]  = '{0, 100, 200, 300, 0,     100,    "ramp_mu0"};
    vecs[1]  = '{0, 100, 200, 300, 8192,  150,    "ramp_half"};
    vecs[2]  = '{0, 100, 200, 300, 16383, 199,    "ramp_max"};
    vecs[3]  = '{0, 100, 200, 300, 20000, 199,    "ramp_clamp"};
    vecs[4]  = '{0, 100, 200, 300, 65535, 199,    "ramp_clamp_top"};
    vecs[5]  = '{0, 32767, 32767, 0, 8192, 32767, "sat_pos"};
    vecs[6]  = '{0, -32768, -32768, 0, 8192, -32768, "sat_neg"};
    vecs[7]  = '{10, -20, 30, -40, 0,     -20,    "curve_mu0"};
    vecs[8]  = '{10, -20, 30, -40, 4096,  -4,     "curve_q"};
    vecs[9]  = '{10, -20, 30, -40, 12288, 21,     "curve_3q"};
    vecs[10] = '{10, -20, 30, -40, 1000,  -16,    "curve_floor"};
    vecs[11] = '{0, 0, 0, 1, 8192,        -1,     "floor_odd"};
    vecs[12] = '{-300, -200, -100, 0, 8192, -150, "ramp_neg"};

    doReset();
    checkOutput("reset_dout", int'(dout), 0);
    checkOutput("reset_valid", int'(dout_valid), 0);

    // Strobes during fill are dropped; only the fifth valid sample's strobe counts
    clearObs();
    applyStimulus(1'b0, 1'b1, 0,   1'b1, 8192);
    applyStimulus(1'b0, 1'b1, 100, 1'b1, 8192);
    applyStimulus(1'b0, 1'b1, 200, 1'b1, 8192);
    idle(5);
    checkOutput("fill_gate_count", obs_val.size(), 0);
    applyStimulus(1'b0, 1'b1, 300, 1'b1, 8192);
    applyStimulus(1'b0, 1'b1, 400, 1'b1, 8192);
    expectOne("ramp_first", 150);

    for (int i = 0; i < 13; i++) begin
      clearObs();
      loadTaps(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0);
      applyStimulus(1'b0, 1'b1, 0, 1'b1, vecs[i].u);
      expectOne(vecs[i].name, vecs[i].exp);
    end

    // Constant input with back-to-back strobes
    doReset();
    clearObs();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1000, (i >= 5 && i <= 7), (i == 6) ? 4096 : ((i == 7) ? 16383 : 0));
    end
    idle(5);
    checkOutput("const_count", obs_val.size(), 3);
    for (int i = 0; i < obs_val.size(); i++) checkOutput($sformatf("const_value%0d", i), obs_val[i], 1000);
    if (obs_val.size() == 3) checkOutput("const_back_to_back", obs_cyc[2] - obs_cyc[0], 2);

    // Strobe without a valid sample is dropped and taps stay frozen
    clearObs();
    loadTaps(0, 100, 200, 300);
    applyStimulus(1'b0, 1'b0, 9999, 1'b1, 8192);
    idle(4);
    checkOutput("gap_count", obs_val.size(), 0);
    applyStimulus(1'b0, 1'b1, 400, 1'b1, 8192);
    expectOne("gap_resume", 150);

    // Reset one cycle after an accepted strobe discards it
    clearObs();
    loadTaps(0, 100, 200, 300);
    applyStimulus(1'b0, 1'b1, 400, 1'b1, 16383);
    applyStimulus(1'b1, 1'b1, 5555, 1'b1, 8192);
    idle(6);
    checkOutput("midreset_count", obs_val.size(), 0);
    checkOutput("midreset_dout", int'(dout), 0);
    checkOutput("midreset_valid", int'(dout_valid), 0);
    applyStimulus(1'b0, 1'b1, 0,   1'b1, 8192);
    applyStimulus(1'b0, 1'b1, 100, 1'b1, 8192);
    applyStimulus(1'b0, 1'b1, 200, 1'b1, 8192);
    applyStimulus(1'b0, 1'b1, 300, 1'b1, 8192);
    applyStimulus(1'b0, 1'b1, 400, 1'b1, 8192);
    expectOne("refill", 150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
